// File: rtl/updown_counter_pkg.sv
// Shared constants and helpers for the up/down counter slice.
// Imported by the counter, its prescaler and the benches.
package updown_counter_pkg;

  localparam bit DIR_UP = 1'b1;
  localparam bit DIR_DN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // ceil(log2(v)), never below 1 so a register can always be declared
  function automatic int cnt_w(input int v);
    int w;
    w = 0;
    while ((1 << w) < v) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/updown_counter_prescaler.sv
// Modulo-PRESCALE enable divider; emits one tick per PRESCALE enables.
// restart returns the phase to zero and suppresses the tick.
module tick_prescaler
  import updown_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int PW = cnt_w(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] ps_q;
  logic [PW-1:0] ps_d;

  assign tick = en & ~restart & (ps_q == LAST);

  always_comb begin
    ps_d = ps_q;
    if (restart) begin
      ps_d = '0;
    end else if (tick) begin
      ps_d = '0;
    end else if (en) begin
      ps_d = ps_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end

endmodule

// File: rtl/updown_counter.sv
// Up/down counter with programmable terminal count, parallel load,
// wrap or saturate behaviour and a clock-enable prescaler.
module updown_counter
  import updown_counter_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter int              SATURATE = 0,
  parameter int              PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             sat,
  output logic             ovf,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
  localparam bit SAT_MODE = (SATURATE == MODE_SAT);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic             ovf_q, ovf_d;
  logic             tick;
  logic [WIDTH-1:0] load_clamp;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .restart(clr | load),
    .tick   (tick)
  );

  assign load_clamp = (load_val > MAXV) ? MAXV : load_val;
  assign at_max     = (count_q == MAXV);
  assign at_min     = (count_q == '0);

  // Range ends are compared before stepping, so the full-width
  // case never relies on natural overflow.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = sat_q;
    ovf_d   = ovf_q;
    priority case (1'b1)
      clr: begin
        count_d = '0;
        sat_d   = 1'b0;
        ovf_d   = 1'b0;
      end
      load: begin
        count_d = load_clamp;
        sat_d   = 1'b0;
      end
      tick: begin
        if (up_dn == DIR_UP) begin
          if (at_max) begin
            ovf_d = 1'b1;
            if (SAT_MODE) begin
              sat_d = 1'b1;
            end else begin
              count_d = '0;
              wrap_d  = 1'b1;
            end
          end else begin
            count_d = count_q + 1'b1;
            sat_d   = 1'b0;
          end
        end else begin
          if (at_min) begin
            ovf_d = 1'b1;
            if (SAT_MODE) begin
              sat_d = 1'b1;
            end else begin
              count_d = MAXV;
              wrap_d  = 1'b1;
            end
          end else begin
            count_d = count_q - 1'b1;
            sat_d   = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign sat   = sat_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter: wrap, saturate and
// prescaled instances driven from one linear sequence.
module tb_updown_counter;
  import updown_counter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // a_*: wrap mode, W4 MAX9
  logic       a_rst, a_clr, a_en, a_ud, a_ld;
  logic [3:0] a_lv, a_cnt;
  logic       a_wrap, a_sat, a_ovf, a_amax, a_amin;
  // b_*: saturate mode, W4 MAX5
  logic       b_rst, b_clr, b_en, b_ud, b_ld;
  logic [3:0] b_lv, b_cnt;
  logic       b_wrap, b_sat, b_ovf, b_amax, b_amin;
  // c_*: wrap mode, W4 MAX15, PRESCALE 3
  logic       c_rst, c_clr, c_en, c_ud, c_ld;
  logic [3:0] c_lv, c_cnt;
  logic       c_wrap, c_sat, c_ovf, c_amax, c_amin;

  updown_counter #(
    .WIDTH(4), .MAX_VAL(9), .SATURATE(0), .PRESCALE(1)
  ) u_wrap (
    .clk(clk), .rst_n(a_rst), .clr(a_clr), .en(a_en),
    .up_dn(a_ud), .load(a_ld), .load_val(a_lv),
    .count(a_cnt), .wrap(a_wrap), .sat(a_sat), .ovf(a_ovf),
    .at_max(a_amax), .at_min(a_amin)
  );

  updown_counter #(
    .WIDTH(4), .MAX_VAL(5), .SATURATE(1), .PRESCALE(1)
  ) u_sat (
    .clk(clk), .rst_n(b_rst), .clr(b_clr), .en(b_en),
    .up_dn(b_ud), .load(b_ld), .load_val(b_lv),
    .count(b_cnt), .wrap(b_wrap), .sat(b_sat), .ovf(b_ovf),
    .at_max(b_amax), .at_min(b_amin)
  );

  updown_counter #(
    .WIDTH(4), .MAX_VAL(15), .SATURATE(0), .PRESCALE(3)
  ) u_pre (
    .clk(clk), .rst_n(c_rst), .clr(c_clr), .en(c_en),
    .up_dn(c_ud), .load(c_ld), .load_val(c_lv),
    .count(c_cnt), .wrap(c_wrap), .sat(c_sat), .ovf(c_ovf),
    .at_max(c_amax), .at_min(c_amin)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    {a_rst, a_clr, a_en, a_ud, a_ld, a_lv} = '0;
    {b_rst, b_clr, b_en, b_ud, b_ld, b_lv} = '0;
    {c_rst, c_clr, c_en, c_ud, c_ld, c_lv} = '0;
    #2;
    chk("rst_cnt", int'(a_cnt), 0);
    chk("rst_min", int'(a_amin), 1);
    chk("rst_max", int'(a_amax), 0);
    chk("rst_ovf", int'(b_ovf), 0);
    edge1();
    {a_rst, b_rst, c_rst} = 3'b111;

    // wrap up 0..9,0,1,2
    a_ud = DIR_UP;
    a_en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      edge1();
      chk("wup_cnt", int'(a_cnt), k % 10);
      chk("wup_wrap", int'(a_wrap), (k == 10) ? 1 : 0);
      chk("wup_ovf", int'(a_ovf), (k >= 10) ? 1 : 0);
    end

    // wrap down
    a_en = 1'b0;
    a_clr = 1'b1;
    edge1();
    a_clr = 1'b0;
    chk("clr_ovf", int'(a_ovf), 0);
    a_ld = 1'b1;
    a_lv = 4'd1;
    edge1();
    a_ld = 1'b0;
    chk("wdn_ld", int'(a_cnt), 1);
    a_ud = DIR_DN;
    a_en = 1'b1;
    edge1();
    chk("wdn_c0", int'(a_cnt), 0);
    chk("wdn_w0", int'(a_wrap), 0);
    edge1();
    chk("wdn_c9", int'(a_cnt), 9);
    chk("wdn_w9", int'(a_wrap), 1);
    chk("wdn_ovf", int'(a_ovf), 1);
    chk("wdn_max", int'(a_amax), 1);
    edge1();
    chk("wdn_c8", int'(a_cnt), 8);
    chk("wdn_w8", int'(a_wrap), 0);
    a_en = 1'b0;
    a_clr = 1'b1;
    edge1();
    a_clr = 1'b0;
    chk("wdn_clr", int'(a_ovf), 0);
    chk("wdn_clrc", int'(a_cnt), 0);

    // priority and clamp
    a_ld = 1'b1;
    a_lv = 4'd13;
    a_en = 1'b1;
    a_ud = DIR_UP;
    edge1();
    chk("clamp", int'(a_cnt), 9);
    chk("clamp_w", int'(a_wrap), 0);
    a_clr = 1'b1;
    edge1();
    {a_clr, a_ld, a_en} = 3'b000;
    chk("clr_ld", int'(a_cnt), 0);

    // saturate
    b_ld = 1'b1;
    b_lv = 4'd4;
    edge1();
    b_ld = 1'b0;
    b_ud = DIR_UP;
    b_en = 1'b1;
    edge1();
    chk("sat_c1", int'(b_cnt), 5);
    chk("sat_s1", int'(b_sat), 0);
    edge1();
    chk("sat_c2", int'(b_cnt), 5);
    chk("sat_s2", int'(b_sat), 1);
    chk("sat_o2", int'(b_ovf), 1);
    edge1();
    chk("sat_c3", int'(b_cnt), 5);
    chk("sat_s3", int'(b_sat), 1);
    chk("sat_nw", int'(b_wrap), 0);
    b_ud = DIR_DN;
    edge1();
    b_en = 1'b0;
    chk("sat_dn", int'(b_cnt), 4);
    chk("sat_dns", int'(b_sat), 0);
    chk("sat_dno", int'(b_ovf), 1);
    b_ld = 1'b1;
    b_lv = 4'd0;
    edge1();
    b_ld = 1'b0;
    b_en = 1'b1;
    edge1();
    b_en = 1'b0;
    chk("sat_lo", int'(b_cnt), 0);
    chk("sat_los", int'(b_sat), 1);
    edge1();
    chk("sat_hold", int'(b_sat), 1);

    // prescaler
    c_ud = DIR_UP;
    c_en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      edge1();
      chk("pre_cnt", int'(c_cnt), k / 3);
    end
    c_en = 1'b0;
    c_clr = 1'b1;
    edge1();
    c_clr = 1'b0;
    chk("pre_clr", int'(c_cnt), 0);
    c_en = 1'b1;
    repeat (4) edge1();
    chk("pre_e4", int'(c_cnt), 1);
    c_en = 1'b0;
    repeat (2) edge1();
    chk("pre_frz", int'(c_cnt), 1);
    c_en = 1'b1;
    edge1();
    chk("pre_e7", int'(c_cnt), 1);
    edge1();
    chk("pre_e8", int'(c_cnt), 2);

    // async reset mid-count
    c_en = 1'b0;
    c_clr = 1'b1;
    edge1();
    c_clr = 1'b0;
    c_ud = DIR_DN;
    c_en = 1'b1;
    repeat (3) edge1();
    chk("pre_wdn", int'(c_cnt), 15);
    chk("pre_wo", int'(c_ovf), 1);
    c_en = 1'b0;
    c_ld = 1'b1;
    c_lv = 4'd7;
    edge1();
    c_ld = 1'b0;
    chk("ar_ld", int'(c_cnt), 7);
    #2;
    c_rst = 1'b0;
    #1;
    chk("ar_cnt", int'(c_cnt), 0);
    chk("ar_ovf", int'(c_ovf), 0);
    chk("ar_min", int'(c_amin), 1);
    edge1();
    c_rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
